// File: rtl/chess_countdown.sv
// Two-player chess clock: one shared prescaler ticks the active player's mm:ss down,
// flagging whoever reaches 00:00 first. Optional per-move increment under `CHESS_INC_EN.
module chess_countdown #(
  parameter int CLK_DIV = 100000000,
  parameter int INC_SEC = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] loadData,
  input  logic        startPause,
  input  logic        playerSel,
  output logic [23:0] countedTime,
  output logic        running,
  output logic        flagA,
  output logic        flagB
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FLAG  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [23:0]     time_q, time_d;
  logic            sel_q, sel_d;
  logic            flag_a_q, flag_a_d;
  logic            flag_b_q, flag_b_d;

  logic [11:0]     act_t;
  logic [11:0]     new_t;
  logic            tc;
  logic            sel_chg;
  logic            hit_zero;

  // Time fields are {min[5:0], sec[5:0]}.
  function automatic logic [11:0] clamp_sec(input logic [11:0] t);
    return {t[11:6], (t[5:0] > 6'd59) ? 6'd59 : t[5:0]};
  endfunction

  function automatic logic [11:0] dec_time(input logic [11:0] t);
    if (t[5:0] != 6'd0)
      return {t[11:6], t[5:0] - 6'd1};
    else if (t[11:6] != 6'd0)
      return {t[11:6] - 6'd1, 6'd59};
    else
      return t;
  endfunction

`ifdef CHESS_INC_EN
  // Add INC_SEC seconds with carry into minutes, saturating at 63:59.
  function automatic logic [11:0] inc_time(input logic [11:0] t);
    int unsigned total;
    total = 32'(t[11:6]) * 60 + 32'(t[5:0]) + 32'(INC_SEC);
    if (total > 32'd3839) total = 32'd3839;
    return {6'(total / 60), 6'(total % 60)};
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    time_d   = time_q;
    sel_d    = playerSel;
    flag_a_d = flag_a_q;
    flag_b_d = flag_b_q;
    hit_zero = 1'b0;
    tc       = (presc_q == PRESC_MAX);
    sel_chg  = (playerSel != sel_q);
    // sel_q is the player who owned the elapsing second, even on the cycle of a switch.
    act_t    = sel_q ? time_q[11:0] : time_q[23:12];
    new_t    = act_t;

    if (load) begin
      time_d   = {clamp_sec(loadData[23:12]), clamp_sec(loadData[11:0])};
      presc_d  = '0;
      flag_a_d = 1'b0;
      flag_b_d = 1'b0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (startPause) state_d = RUN;
        PAUSE: if (startPause) state_d = RUN;
        FLAG:  state_d = FLAG;
        RUN: begin
          if (act_t == 12'd0) begin
            hit_zero = 1'b1;
          end else begin
            new_t = tc ? dec_time(act_t) : act_t;
            if (new_t == 12'd0) hit_zero = 1'b1;
`ifdef CHESS_INC_EN
            else if (sel_chg) new_t = inc_time(new_t);
`endif
          end
          presc_d = (sel_chg || tc) ? '0 : presc_q + 1'b1;
          if (sel_q) time_d[11:0] = new_t;
          else       time_d[23:12] = new_t;
          if (hit_zero) begin
            if (sel_q) flag_b_d = 1'b1;
            else       flag_a_d = 1'b1;
            state_d = FLAG;
          end else if (startPause) begin
            state_d = PAUSE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      time_q   <= 24'h000000;
      sel_q    <= 1'b0;
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      time_q   <= time_d;
      sel_q    <= sel_d;
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
    end
  end

  assign countedTime = time_q;
  assign running     = (state_q == RUN);
  assign flagA       = flag_a_q;
  assign flagB       = flag_b_q;

endmodule

// File: doc/chess_countdown.md
CHESS_COUNTDOWN -- requirements
Module: chess_countdown

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100000000, giving clk cycles per countdown second.
REQ-002 The block SHALL have parameter INC_SEC, default 5, giving increment seconds (used only with CHESS_INC_EN).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port load, input, 1 bit: one-cycle pulse that loads loadData into both players' times.
REQ-006 The block SHALL have port loadData, input, 24 bits: packed {minA[5:0], secA[5:0], minB[5:0], secB[5:0]}, the format of the time-select output.
REQ-007 The block SHALL have port startPause, input, 1 bit: one-cycle pulse that toggles run/pause.
REQ-008 The block SHALL have port playerSel, input, 1 bit, level: 0 selects player A, 1 selects player B as active.
REQ-009 The block SHALL have port countedTime, output, 24 bits, registered: current times in loadData packing.
REQ-010 The block SHALL have port running, output, 1 bit: high in state RUN.
REQ-011 The block SHALL have ports flagA and flagB, output, 1 bit each: player A or B reached 00:00 while active.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, PAUSE and FLAG.
REQ-013 load SHALL have priority in every state: times load, prescaler clears to 0, flags clear, next state IDLE.
REQ-014 On load, any seconds field above 59 SHALL be stored as 59; minutes SHALL store unchanged (0..63).
REQ-015 startPause SHALL move IDLE to RUN, RUN to PAUSE and PAUSE to RUN; it SHALL be ignored in FLAG and when coincident with load.
REQ-016 In RUN, the prescaler SHALL count 0..CLK_DIV-1 and wrap; at terminal count the active player's time SHALL decrement by one second.
REQ-017 Decrement: sec>0 gives sec-1; sec=0 with min>0 gives min-1 and sec=59; times of 00:00 SHALL never decrement.
REQ-018 When a decrement yields 00:00, the active player's flag SHALL set and the state SHALL move to FLAG on the same edge.
REQ-019 On entry to RUN with the active player already at 00:00, the block SHALL set that flag and enter FLAG on the next cycle.
REQ-020 In PAUSE, IDLE and FLAG, the prescaler and all times SHALL hold.
REQ-021 A playerSel change in RUN, detected against a registered copy, SHALL clear the prescaler to 0 so the new player gets a full second.
REQ-022 If a terminal count and a playerSel change occur in the same cycle, the decrement SHALL apply to the previously active player.
REQ-023 The inactive player's time SHALL never change except by load (or by increment, see REQ-027).
REQ-024 Flags SHALL stay set until load or rst.

Reset
REQ-025 rst SHALL immediately force: state IDLE, countedTime 24'h000000, prescaler 0, running 0, flagA 0, flagB 0, registered playerSel 0.
REQ-026 rst asserted mid-RUN SHALL abort the count; after release the block SHALL stay in IDLE until startPause.

Configuration
REQ-027 With macro CHESS_INC_EN defined, each playerSel change in RUN SHALL add INC_SEC seconds to the player who just moved, with seconds carry into minutes, saturating at 63:59. When this coincides with that player's decrement (REQ-022), the decrement SHALL apply first. No increment SHALL apply if that player's result is 00:00 (that player flags instead).
REQ-028 Without CHESS_INC_EN, no increment logic SHALL exist, and playerSel changes SHALL only clear the prescaler.

Verification (CLK_DIV=4, INC_SEC=5)
REQ-029 The bench SHALL cover: load 24'h041_041 (A=B=01:01), playerSel=0, startPause -> after 4 clks A=01:00; after 8 clks A=00:59; B unchanged.
REQ-030 The bench SHALL cover: A=00:01 running -> at terminal count A=00:00, flagA=1, running=0; a further startPause is ignored.
REQ-031 The bench SHALL cover: running, toggle playerSel at prescaler=3 -> the decrement hits the old player and the prescaler restarts at 0 for the new player; with CHESS_INC_EN the old player nets +4 s.
REQ-032 The bench SHALL cover: load with secA=62 -> countedTime secA=59; load asserted during RUN -> IDLE, flags cleared, new times shown.
REQ-033 The bench SHALL cover: rst asserted mid-RUN -> all outputs 0 immediately; after release, tick periods elapse with no change until startPause.
REQ-034 The bench SHALL cover: startPause in RUN -> PAUSE; times hold for 20 clks; startPause -> RUN resumes from the held prescaler value.
